// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART operand receiver.
// Holds the bit-FSM state encoding and the baud divisor selector.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    localparam int DIV_W = 16;

    function automatic logic [DIV_W-1:0] sel_div(
        input logic [1:0]       freq_control,
        input logic [DIV_W-1:0] div0,
        input logic [DIV_W-1:0] div1,
        input logic [DIV_W-1:0] div2,
        input logic [DIV_W-1:0] div3
    );
        logic [DIV_W-1:0] div;
        case (freq_control)
            2'b00:   div = div0;
            2'b01:   div = div1;
            2'b10:   div = div2;
            default: div = div3;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_operand_rx_byte.sv
// 8N1 byte receiver: input synchroniser, start/data/stop bit FSM, bit timer and shift register.
// byte_valid and framing_error are single-cycle pulses in the stop-sample cycle.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int BAUD_DIV0 = 434,
    parameter int BAUD_DIV1 = 217,
    parameter int BAUD_DIV2 = 109,
    parameter int BAUD_DIV3 = 54
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic [1:0] freq_control,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [DIV_W-1:0] D0 = DIV_W'(BAUD_DIV0);
    localparam logic [DIV_W-1:0] D1 = DIV_W'(BAUD_DIV1);
    localparam logic [DIV_W-1:0] D2 = DIV_W'(BAUD_DIV2);
    localparam logic [DIV_W-1:0] D3 = DIV_W'(BAUD_DIV3);

    logic             sync_q;
    logic             rx_s_q;
    logic             rx_prev_q;
    uart_rx_state_t   state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [DIV_W-1:0] cur_div;

    assign cur_div   = sel_div(freq_control, D0, D1, D2, D3);
    assign byte_data = shift_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= D0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            sync_q    <= uart_rx;
            rx_s_q    <= sync_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        div_d         = div_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        byte_valid    = 1'b0;
        framing_error = 1'b0;
        if (!rx_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // Divisor is frozen here so freq_control changes only affect the next byte.
                    if (rx_prev_q && !rx_s_q) begin
                        div_d   = cur_div;
                        cnt_d   = (cur_div >> 1) - 16'd1;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            cnt_d   = div_q - 16'd1;
                            bit_d   = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        cnt_d   = div_q - 16'd1;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == '0) begin
                        state_d       = IDLE;
                        byte_valid    = rx_s_q;
                        framing_error = !rx_s_q;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_operand_rx.sv
// Pairs received UART bytes into operands A/B and offers them on a valid/ready output register.
// A completed pair that finds the output register occupied is dropped and flagged as overrun.
module uart_operand_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV0 = 434,
    parameter int BAUD_DIV1 = 217,
    parameter int BAUD_DIV2 = 109,
    parameter int BAUD_DIV3 = 54
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic [1:0] freq_control,
    input  logic       uart_rx,
    input  logic       pair_ready,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       pair_valid,
    output logic       frames_received,
    output logic       framing_error,
    output logic       overrun,
    output logic       rx_busy
);

    logic       byte_valid;
    logic       byte_ferr;
    logic [7:0] byte_data;

    uart_rx_byte #(
        .BAUD_DIV0(BAUD_DIV0),
        .BAUD_DIV1(BAUD_DIV1),
        .BAUD_DIV2(BAUD_DIV2),
        .BAUD_DIV3(BAUD_DIV3)
    ) u_byte (
        .clk          (clk),
        .reset        (reset),
        .rx_enable    (rx_enable),
        .freq_control (freq_control),
        .uart_rx      (uart_rx),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .framing_error(byte_ferr),
        .busy         (rx_busy)
    );

    logic       idx_q, idx_d;
    logic [7:0] a_hold_q, a_hold_d;
    logic [7:0] op_a_q, op_a_d;
    logic [7:0] op_b_q, op_b_d;
    logic       pair_valid_q, pair_valid_d;
    logic       frames_q, frames_d;
    logic       ferr_q, ferr_d;
    logic       overrun_q, overrun_d;

    assign op_a            = op_a_q;
    assign op_b            = op_b_q;
    assign pair_valid      = pair_valid_q;
    assign frames_received = frames_q;
    assign framing_error   = ferr_q;
    assign overrun         = overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= 1'b0;
            a_hold_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            pair_valid_q <= 1'b0;
            frames_q     <= 1'b0;
            ferr_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            a_hold_q     <= a_hold_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            pair_valid_q <= pair_valid_d;
            frames_q     <= frames_d;
            ferr_q       <= ferr_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        idx_d        = idx_q;
        a_hold_d     = a_hold_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        pair_valid_d = pair_valid_q;
        frames_d     = 1'b0;
        ferr_d       = byte_ferr;
        overrun_d    = 1'b0;
        if (pair_valid_q && pair_ready) begin
            pair_valid_d = 1'b0;
        end
        if (byte_valid) begin
            idx_d = !idx_q;
            if (!idx_q) begin
                a_hold_d = byte_data;
            end else if (!pair_valid_q || pair_ready) begin
                // Output is free now, including the case where the old pair is consumed this cycle.
                op_a_d       = a_hold_q;
                op_b_d       = byte_data;
                pair_valid_d = 1'b1;
                frames_d     = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (byte_ferr || !rx_enable) begin
            idx_d = 1'b0;
        end
    end

endmodule

// File: doc/uart_operand_rx.md
# uart_operand_rx

UART receive front-end that feeds the multiplier core's operand port when the UART link is selected. Oversamples the `uart_rx` line, deserialises 8N1 bytes, and pairs consecutive bytes into operand A and operand B. Presents each completed pair on a valid/ready handshake to the downstream multiply stage. Pulses `frames_received` when a pair is accepted into the output register.

## Interface

Parameters:
- `BAUD_DIV0`, default 434: clock cycles per bit when `freq_control = 2'b00`.
- `BAUD_DIV1`, default 217: clock cycles per bit for `2'b01`.
- `BAUD_DIV2`, default 109: clock cycles per bit for `2'b10`.
- `BAUD_DIV3`, default 54: clock cycles per bit for `2'b11`.
- Every divisor is ≥ 4 and < 2^16.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset` in 1: reset, synchronous and active-high.
- `rx_enable` in 1: driven from `communication_sel` (1 = UART). While low, the receiver is held idle.
- `freq_control` in 2: baud divisor select.
- `uart_rx` in 1: asynchronous serial input, idle high.
- `pair_ready` in 1: downstream is ready to accept a pair.
- `op_a` out 8: first byte of the pair.
- `op_b` out 8: second byte of the pair.
- `pair_valid` out 1: `op_a` and `op_b` hold an unconsumed pair.
- `frames_received` out 1: one-cycle pulse when a new pair is loaded into `op_a`/`op_b`.
- `framing_error` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a completed pair is dropped.
- `rx_busy` out 1: bit FSM is not in IDLE.

## Operation

- **Input synchroniser:** 2-FF synchroniser on `uart_rx`; both flops reset to 1. All logic uses the synchronised value `rx_s`.
- **Divisor latch:** the divisor is chosen from `freq_control` and latched at start-edge detection. Changes to `freq_control` mid-byte have no effect until the next byte.
- **Bit FSM states:** IDLE, START, DATA, STOP.
- **IDLE → START:** on a falling edge of `rx_s` with `rx_enable` = 1. The bit counter loads `DIV/2 - 1`.
- **START:** when the counter expires, sample `rx_s`.
  - 0 → DATA, counter reloads `DIV - 1`.
  - 1 → IDLE. This is a glitch: no pulse, nothing is stored.
- **DATA:** sample 8 bits, LSB first, one every `DIV` cycles, into a shift register. After bit 7 → STOP.
- **STOP:** sample after `DIV` cycles, then → IDLE in the same cycle.
  - 1 → byte valid.
  - 0 → `framing_error` pulse, byte discarded, pairing index reset to A.
- **Pairing:** a 1-bit index selects the destination.
  - Index A: byte goes to the internal `a_hold`; index toggles to B.
  - Index B: the pair `{a_hold, byte}` is complete; index toggles back to A.
- **Completed pair, output free:** if `pair_valid` = 0, or `pair_valid & pair_ready` in this same cycle, load `op_a`/`op_b`. Set `pair_valid` and pulse `frames_received`.
- **Completed pair, output occupied:** otherwise the pair is dropped, `overrun` pulses, and `op_a`/`op_b` are unchanged.
- **Handshake:** `pair_valid` clears on `pair_valid & pair_ready` unless a new pair loads in the same cycle. `op_a`/`op_b` are stable while `pair_valid` = 1.
- **`rx_enable` low:**
  - FSM forced to IDLE and pairing index reset to A.
  - A pending `pair_valid` is retained and can still be consumed.
- **Reset values:**
  - `op_a` = `op_b` = 0.
  - `pair_valid`, `frames_received`, `framing_error`, `overrun`, `rx_busy` = 0.
  - Pairing index = A, FSM = IDLE.

## Timing

- Synchroniser latency: 2 cycles from the `uart_rx` pin to `rx_s`.
- Timeline from the first IDLE cycle seeing `rx_s` = 0 (cycle t):
  - Start-bit sample at t + `DIV/2`.
  - Data bit i sampled at t + `DIV/2` + (i+1)·`DIV`.
  - Stop bit sampled at t + `DIV/2` + 9·`DIV`.
- `pair_valid` / `frames_received` assert the cycle after the second byte's stop sample (registered).
- FSM is back in IDLE immediately after the stop sample, so back-to-back bytes with no idle gap are received.
- A pair completing in the same cycle that the old pair is consumed loads without `overrun`.
- A start edge arriving in the same cycle that `rx_enable` falls is ignored.
- Reset mid-byte: the partial byte and a held operand A are discarded; outputs return to reset values on the next edge.

## Structure

- **Shared package `uart_pkg`:**
  - Enum `uart_rx_state_t` {IDLE, START, DATA, STOP}.
  - `DIV_W` = 16.
  - Function `sel_div(freq_control, BAUD_DIV0..3)` returning the divisor.
- **Sub-module `uart_rx_byte`:** synchroniser, bit FSM, counter and shift register. Outputs `byte_valid` pulse, `byte_data`, `framing_error`, `busy`.
- **Top:** holds the pairing index, `a_hold`, the output register and the handshake.

## Test plan

- **Reset:** assert `reset` for 3 cycles with `uart_rx` = 1 → all outputs 0, `rx_busy` = 0.
- **Single pair:** `freq_control` = 00, send 0x0C then 0x0A with `pair_ready` = 0 → `op_a` = 0x0C, `op_b` = 0x0A, `pair_valid` = 1, exactly one `frames_received` pulse one cycle after the stop sample. Raise `pair_ready` → `pair_valid` clears the next cycle.
- **Glitch and framing error:**
  - Hold `uart_rx` low for `DIV/2 - 4` cycles → no state change after return to IDLE.
  - Send byte 0x55 with stop = 0 → `framing_error` pulse.
  - Then send 0x03, 0x07 → pair (0x03, 0x07).
- **Overrun:** `pair_ready` = 0, send pairs (0x11, 0x22) then (0x33, 0x44) → outputs stay 0x11/0x22, one `overrun` pulse, one `frames_received` pulse total.
- **Fast back-to-back:** `freq_control` = 11, send 0xFF, 0x80 with no idle gap and `pair_ready` = 1 → pair (0xFF, 0x80). Change `freq_control` to 00 during the data bits → the byte is still received at `DIV3`.
- **Reset and disable mid-byte:**
  - Assert `reset` mid-data of byte B → no pair. Then send 0x01, 0x02 → pair (0x01, 0x02).
  - Drop `rx_enable` after byte A → A is discarded.
